// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, parity modes.
package uart_pkg;

   localparam int DATA_BITS   = 8;
   localparam int PARITY_EVEN = 0;
   localparam int PARITY_ODD  = 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_t;

   // Parity bit for a byte: even parity makes the total count of ones even.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_parity_if.sv
// Producer-side byte handshake into the UART transmitter.
interface uart_tx_parity_if;
   import uart_pkg::*;

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..last while enabled and flags the final cycle.
module uart_bit_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] last,
   output logic [CNT_W-1:0] count,
   output logic             bit_end
);

   assign bit_end = enable && (count == last);

   // Advance within the bit period, wrapping to zero on the boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (enable) begin
         count <= bit_end ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop bit(s),
// with a one-entry holding buffer so frames can go out back-to-back.
//
// state    | meaning
// S_IDLE   | line high, waiting for a buffered byte
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit
// S_STOP   | stop bit(s) high; last cycle pulses done
module uart_tx_parity #(
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_parity_if.slave   tx,
   output logic              data_line,
   output logic              busy,
   output logic              done
);
   import uart_pkg::*;

   localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
   localparam int CNT_W     = (STOP_CLKS > 2) ? $clog2(STOP_CLKS) : 1;
   localparam int IDX_W     = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
   // One cycle ahead of the stop period's end, so done can be registered.
   localparam logic [CNT_W-1:0] STOP_PRE  = CNT_W'(STOP_CLKS - 2);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic             ODD_MODE  = (PARITY_ODD != PARITY_EVEN);

   uart_state_t          state;
   logic [DATA_BITS-1:0] shift;
   logic                 parity;
   logic [IDX_W-1:0]     bit_idx;

   logic                 buf_full;
   logic [DATA_BITS-1:0] buf_data;

   logic [CNT_W-1:0]     count;
   logic                 bit_end;
   logic                 timer_en;
   logic [CNT_W-1:0]     timer_last;
   logic                 pop;
   logic                 push;

   assign timer_en    = (state != S_IDLE);
   assign timer_last  = (state == S_STOP) ? STOP_LAST : BIT_LAST;
   // Buffer drains into the shifter from idle, or straight from the final stop cycle.
   assign pop         = buf_full && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
   assign push        = tx.tx_valid && !buf_full;
   assign tx.tx_ready = !buf_full;

   uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .enable  (timer_en),
      .last    (timer_last),
      .count   (count),
      .bit_end (bit_end)
   );

   // Holding buffer: filled by the producer, emptied when a frame is launched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full <= 1'b0;
         buf_data <= '0;
      end else if (pop) begin
         buf_full <= 1'b0;
      end else if (push) begin
         buf_full <= 1'b1;
         buf_data <= tx.tx_data;
      end
   end

   // Frame sequencer with registered line, busy and done outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         shift     <= '0;
         parity    <= 1'b0;
         bit_idx   <= '0;
         data_line <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (pop) begin
            shift     <= buf_data;
            parity    <= parity_bit(buf_data, ODD_MODE);
            bit_idx   <= '0;
            state     <= S_START;
            data_line <= 1'b0;
            busy      <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  data_line <= 1'b1;
               end
               S_START: begin
                  if (bit_end) begin
                     state     <= S_DATA;
                     data_line <= shift[0];
                  end
               end
               S_DATA: begin
                  if (bit_end) begin
                     if (bit_idx == IDX_LAST) begin
                        state     <= S_PARITY;
                        data_line <= parity;
                     end else begin
                        shift     <= shift >> 1;
                        data_line <= shift[1];
                        bit_idx   <= bit_idx + 1'b1;
                     end
                  end
               end
               S_PARITY: begin
                  if (bit_end) begin
                     state     <= S_STOP;
                     data_line <= 1'b1;
                  end
               end
               S_STOP: begin
                  if (bit_end) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else if (count == STOP_PRE) begin
                     done <= 1'b1;
                  end
               end
               default: begin
                  state     <= S_IDLE;
                  data_line <= 1'b1;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed bench for uart_tx_parity: default, odd-parity and two-stop-bit builds.
module tb_uart_tx_parity;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_parity_if a_if ();
   uart_tx_parity_if o_if ();
   uart_tx_parity_if s_if ();

   logic a_line, a_busy, a_done;
   logic o_line, o_busy, o_done;
   logic s_line, s_busy, s_done;

   uart_tx_parity u_a (
      .clk(clk), .rst(rst), .tx(a_if.slave),
      .data_line(a_line), .busy(a_busy), .done(a_done)
   );
   uart_tx_parity #(.PARITY_ODD(1)) u_o (
      .clk(clk), .rst(rst), .tx(o_if.slave),
      .data_line(o_line), .busy(o_busy), .done(o_done)
   );
   uart_tx_parity #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_s (
      .clk(clk), .rst(rst), .tx(s_if.slave),
      .data_line(s_line), .busy(s_busy), .done(s_done)
   );

   int total = 0;
   int bad   = 0;

   logic rec_line  [0:299];
   logic rec_done  [0:299];
   logic rec_busy  [0:299];
   logic rec_ready [0:299];

   // Present a byte for one accept edge, then scramble tx_data; returns on the idle cycle after accept.
   task automatic start_tx(input int which, input logic [7:0] b);
      @(negedge clk);
      case (which)
         0: begin a_if.tx_valid = 1'b1; a_if.tx_data = b; end
         1: begin o_if.tx_valid = 1'b1; o_if.tx_data = b; end
         default: begin s_if.tx_valid = 1'b1; s_if.tx_data = b; end
      endcase
      @(posedge clk);
      #1;
      a_if.tx_valid = 1'b0; o_if.tx_valid = 1'b0; s_if.tx_valid = 1'b0;
      a_if.tx_data = ~b; o_if.tx_data = ~b; s_if.tx_data = ~b;
      @(negedge clk);
   endtask

   task automatic record(input int which, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         case (which)
            0: begin rec_line[c] = a_line; rec_done[c] = a_done; rec_busy[c] = a_busy; rec_ready[c] = a_if.tx_ready; end
            1: begin rec_line[c] = o_line; rec_done[c] = o_done; rec_busy[c] = o_busy; rec_ready[c] = o_if.tx_ready; end
            default: begin rec_line[c] = s_line; rec_done[c] = s_done; rec_busy[c] = s_busy; rec_ready[c] = s_if.tx_ready; end
         endcase
      end
   endtask

   // Byte from mid-bit samples of an 8-clock-per-bit frame starting at base.
   function automatic logic [7:0] dec8(input int base);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) d[i] = rec_line[base + 12 + 8*i];
      return d;
   endfunction

   function automatic int count_done(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (rec_done[i] === 1'b1) n++;
      return n;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      #12;
      total++; if (a_line !== 1'b1) begin bad++; $display("FAIL reset_line got=%b want=1", a_line); end
      total++; if (a_if.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_if.tx_ready); end
      total++; if ({a_busy, a_done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b want=00", {a_busy, a_done}); end
      total++; if ({s_line, s_busy, s_done} !== 3'b100) begin bad++; $display("FAIL reset_stop2 got=%b want=100", {s_line, s_busy, s_done}); end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frame_a5();
      logic exp_bits [0:10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int   errs = 0;
      int   busy_errs = 0;
      int   first_done = -1;
      start_tx(0, 8'hA5);
      total++; if ({a_line, a_busy, a_if.tx_ready} !== 3'b100) begin bad++; $display("FAIL a5_accept_cycle got=%b want=100", {a_line, a_busy, a_if.tx_ready}); end
      record(0, 90);
      for (int c = 0; c < 88; c++) begin
         if (rec_line[c] !== exp_bits[c/8]) errs++;
         if (rec_busy[c] !== 1'b1) busy_errs++;
      end
      for (int c = 89; c >= 0; c--) if (rec_done[c] === 1'b1) first_done = c;
      total++; if (errs != 0) begin bad++; $display("FAIL a5_line_bits got=%0d wrong cycles want=0", errs); end
      total++; if (first_done != 87 || count_done(0, 89) != 1) begin bad++; $display("FAIL a5_done got=cycle %0d x%0d want=cycle 87 x1", first_done, count_done(0, 89)); end
      total++; if (busy_errs != 0 || rec_busy[88] !== 1'b0) begin bad++; $display("FAIL a5_busy got=%0d low cycles, after=%b want=0,0", busy_errs, rec_busy[88]); end
      total++; if (rec_ready[0] !== 1'b1) begin bad++; $display("FAIL a5_ready_after_start got=%b want=1", rec_ready[0]); end
      total++; if (rec_line[88] !== 1'b1) begin bad++; $display("FAIL a5_idle_after got=%b want=1", rec_line[88]); end
   endtask

   task automatic test_parity_odd();
      logic [7:0] vals [0:2] = '{8'h01, 8'h03, 8'h00};
      logic       pars [0:2] = '{1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 3; k++) begin
         start_tx(1, vals[k]);
         record(1, 90);
         total++; if (rec_line[76] !== pars[k]) begin bad++; $display("FAIL odd_parity_%0d got=%b want=%b", k, rec_line[76], pars[k]); end
         total++; if (dec8(0) !== vals[k]) begin bad++; $display("FAIL odd_data_%0d got=%h want=%h", k, dec8(0), vals[k]); end
         total++; if (rec_done[87] !== 1'b1 || rec_line[84] !== 1'b1) begin bad++; $display("FAIL odd_stop_done_%0d got=%b%b want=11", k, rec_done[87], rec_line[84]); end
      end
   endtask

   task automatic test_back_to_back();
      int busy_errs = 0;
      start_tx(0, 8'h00);
      for (int c = 0; c < 180; c++) begin
         @(negedge clk);
         rec_line[c] = a_line; rec_done[c] = a_done; rec_busy[c] = a_busy; rec_ready[c] = a_if.tx_ready;
         if (c == 20) begin a_if.tx_valid = 1'b1; a_if.tx_data = 8'hFF; end
         if (c == 21) begin a_if.tx_valid = 1'b0; a_if.tx_data = 8'h5C; end
      end
      for (int c = 0; c < 176; c++) if (rec_busy[c] !== 1'b1) busy_errs++;
      total++; if (rec_done[87] !== 1'b1 || rec_done[175] !== 1'b1 || count_done(0, 179) != 2) begin bad++; $display("FAIL b2b_done got=%b,%b x%0d want=1,1 x2", rec_done[87], rec_done[175], count_done(0, 179)); end
      total++; if ({rec_line[87], rec_line[88]} !== 2'b10) begin bad++; $display("FAIL b2b_no_gap got=%b want=10", {rec_line[87], rec_line[88]}); end
      total++; if (dec8(0) !== 8'h00 || dec8(88) !== 8'hFF) begin bad++; $display("FAIL b2b_bytes got=%h,%h want=00,ff", dec8(0), dec8(88)); end
      total++; if ({rec_line[76], rec_line[164]} !== 2'b00) begin bad++; $display("FAIL b2b_parity got=%b want=00", {rec_line[76], rec_line[164]}); end
      total++; if (rec_ready[21] !== 1'b0 || rec_ready[88] !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b%b want=01", rec_ready[21], rec_ready[88]); end
      total++; if (busy_errs != 0 || rec_busy[176] !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%0d,%b want=0,0", busy_errs, rec_busy[176]); end
   endtask

   task automatic test_hold_full();
      int acc_c = -1;
      int ready_hi = 0;
      start_tx(0, 8'h11);
      for (int c = 0; c < 267; c++) begin
         @(negedge clk);
         rec_line[c] = a_line; rec_done[c] = a_done; rec_busy[c] = a_busy; rec_ready[c] = a_if.tx_ready;
         if (c == 5) begin a_if.tx_valid = 1'b1; a_if.tx_data = 8'h22; end
         if (c == 6) a_if.tx_data = 8'h3C;
         if (c > 6 && acc_c >= 0 && c == acc_c + 1) begin a_if.tx_valid = 1'b0; a_if.tx_data = 8'hE7; end
         if (c >= 6 && acc_c < 0 && a_if.tx_ready === 1'b1) acc_c = c;
         if (c >= 6 && c < 88 && a_if.tx_ready !== 1'b0) ready_hi++;
      end
      a_if.tx_valid = 1'b0;
      total++; if (ready_hi != 0) begin bad++; $display("FAIL hold_ready_low got=%0d high cycles want=0", ready_hi); end
      total++; if (acc_c != 88) begin bad++; $display("FAIL hold_accept_cycle got=%0d want=88", acc_c); end
      total++; if (dec8(0) !== 8'h11 || dec8(88) !== 8'h22 || dec8(176) !== 8'h3C) begin bad++; $display("FAIL hold_bytes got=%h,%h,%h want=11,22,3c", dec8(0), dec8(88), dec8(176)); end
      total++; if (count_done(0, 266) != 3 || rec_busy[264] !== 1'b0 || rec_line[266] !== 1'b1) begin bad++; $display("FAIL hold_no_dup got=done x%0d busy=%b line=%b want=x3 0 1", count_done(0, 266), rec_busy[264], rec_line[266]); end
   endtask

   task automatic test_reset_mid();
      start_tx(0, 8'h0F);
      for (int c = 0; c < 44; c++) begin
         @(negedge clk);
         if (c == 10) begin a_if.tx_valid = 1'b1; a_if.tx_data = 8'h33; end
         if (c == 11) a_if.tx_valid = 1'b0;
      end
      total++; if (a_line !== 1'b0) begin bad++; $display("FAIL rstmid_bit4_before got=%b want=0", a_line); end
      rst = 1'b1;
      #1;
      total++; if ({a_line, a_busy, a_if.tx_ready} !== 3'b101) begin bad++; $display("FAIL rstmid_immediate got=%b want=101", {a_line, a_busy, a_if.tx_ready}); end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({a_line, a_busy} !== 2'b10) begin bad++; $display("FAIL rstmid_buffer_flushed got=%b want=10", {a_line, a_busy}); end
      start_tx(0, 8'h5A);
      record(0, 90);
      total++; if (dec8(0) !== 8'h5A || {rec_line[4], rec_line[76], rec_line[84]} !== 3'b001) begin bad++; $display("FAIL rstmid_fresh got=%h %b want=5a 001", dec8(0), {rec_line[4], rec_line[76], rec_line[84]}); end
      total++; if (rec_done[87] !== 1'b1 || count_done(0, 89) != 1) begin bad++; $display("FAIL rstmid_done got=%b x%0d want=1 x1", rec_done[87], count_done(0, 89)); end
   endtask

   task automatic test_stop2();
      logic exp_bits [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int errs = 0;
      int stop_errs = 0;
      start_tx(2, 8'h80);
      record(2, 50);
      for (int c = 0; c < 40; c++) if (rec_line[c] !== exp_bits[c/4]) errs++;
      for (int c = 40; c < 48; c++) if (rec_line[c] !== 1'b1) stop_errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL stop2_bits got=%0d wrong cycles want=0", errs); end
      total++; if (stop_errs != 0) begin bad++; $display("FAIL stop2_stop_high got=%0d low cycles want=0", stop_errs); end
      total++; if (rec_done[47] !== 1'b1 || count_done(0, 49) != 1) begin bad++; $display("FAIL stop2_done got=%b x%0d want=1 x1", rec_done[47], count_done(0, 49)); end
      total++; if ({rec_busy[47], rec_busy[48]} !== 2'b10) begin bad++; $display("FAIL stop2_len got=%b want=10", {rec_busy[47], rec_busy[48]}); end
   endtask

   initial begin
      a_if.tx_valid = 1'b0; a_if.tx_data = 8'h00;
      o_if.tx_valid = 1'b0; o_if.tx_data = 8'h00;
      s_if.tx_valid = 1'b0; s_if.tx_data = 8'h00;
      test_reset();
      test_frame_a5();
      test_parity_odd();
      test_back_to_back();
      test_hold_full();
      test_reset_mid();
      test_stop2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
